// File: rtl/pc2mcu_uart_tx.sv
// pc2mcu_uart_tx: FIFO-buffered UART transmitter, 8N1 by default or 8E1 when
// PC2MCU_UART_PARITY_EN is defined, with a 3-bit run-time baud select.
module pc2mcu_uart_tx #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic [2:0]                  tx_baud,
   input  logic [7:0]                  wr_dat,
   input  logic                        wr_en,
   output logic                        full,
   output logic                        empty,
   output logic [$clog2(FIFO_DEPTH):0] level,
   output logic                        ovf,
   output logic                        tx,
   output logic                        tx_ing,
   output logic                        tx_ok
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLK_HZ / 9600);

   // Divisors are stored minus one so the bit counter can run down to zero.
   localparam logic [CW-1:0] DIV_115200 = CW'(CLK_HZ / 115200 - 1);
   localparam logic [CW-1:0] DIV_57600  = CW'(CLK_HZ / 57600 - 1);
   localparam logic [CW-1:0] DIV_38400  = CW'(CLK_HZ / 38400 - 1);
   localparam logic [CW-1:0] DIV_19200  = CW'(CLK_HZ / 19200 - 1);
   localparam logic [CW-1:0] DIV_9600   = CW'(CLK_HZ / 9600 - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef PC2MCU_UART_PARITY_EN
      PARITY,
`endif
      STOP
   } state_e;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
   logic          full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
   logic          push, pop;
   logic [7:0]    headDat;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, div_q, div_d, baudDiv;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d, ing_q, ing_d, ok_q, ok_d;
   logic          bitEnd;
`ifdef PC2MCU_UART_PARITY_EN
   logic          par_q, par_d;
`endif

   // Full is taken from the registered flag, so a pop in the same cycle
   // never makes room for a write.
   assign push    = wr_en & ~full_q;
   assign pop     = (state_q == IDLE) & ~empty_q;
   assign headDat = mem_q[rptr_q[AW-1:0]];
   assign bitEnd  = (cnt_q == '0);

   always_comb begin
      wptr_d  = wptr_q + {{AW{1'b0}}, push};
      rptr_d  = rptr_q + {{AW{1'b0}}, pop};
      level_d = wptr_d - rptr_d;
      empty_d = (wptr_d == rptr_d);
      full_d  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
      ovf_d   = wr_en & full_q;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q[AW-1:0]] <= wr_dat;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         empty_q <= empty_d;
         full_q  <= full_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      unique case (tx_baud)
         3'd1:    baudDiv = DIV_57600;
         3'd2:    baudDiv = DIV_38400;
         3'd3:    baudDiv = DIV_19200;
         3'd4:    baudDiv = DIV_9600;
         default: baudDiv = DIV_115200;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = bitEnd ? div_q : cnt_q - 1'b1;
      div_d   = div_q;
      bit_d   = bit_q;
      shift_d = shift_q;
`ifdef PC2MCU_UART_PARITY_EN
      par_d   = par_q;
`endif
      unique case (state_q)
         IDLE: begin
            cnt_d = cnt_q;
            if (!empty_q) begin
               shift_d = headDat;
               div_d   = baudDiv;
               cnt_d   = baudDiv;
               state_d = START;
`ifdef PC2MCU_UART_PARITY_EN
               par_d   = ^headDat;
`endif
            end
         end
         START: begin
            if (bitEnd) begin
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (bitEnd) begin
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == 3'd7) begin
`ifdef PC2MCU_UART_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef PC2MCU_UART_PARITY_EN
         PARITY: begin
            if (bitEnd) begin
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (bitEnd) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Line outputs follow the state one cycle late, which also places the
   // done pulse in the first cycle after the last stop-bit cycle.
   always_comb begin
      tx_d = 1'b1;
      unique case (state_q)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_q[0];
`ifdef PC2MCU_UART_PARITY_EN
         PARITY:  tx_d = par_q;
`endif
         default: tx_d = 1'b1;
      endcase
      ing_d = (state_q != IDLE);
      ok_d  = ing_q && (state_q == IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         div_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         ing_q   <= 1'b0;
         ok_q    <= 1'b0;
`ifdef PC2MCU_UART_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         ing_q   <= ing_d;
         ok_q    <= ok_d;
`ifdef PC2MCU_UART_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign full   = full_q;
   assign empty  = empty_q;
   assign level  = level_q;
   assign ovf    = ovf_q;
   assign tx     = tx_q;
   assign tx_ing = ing_q;
   assign tx_ok  = ok_q;

endmodule

// File: tb/tb_pc2mcu_uart_tx.sv
// tb_pc2mcu_uart_tx: directed and randomized checks of pc2mcu_uart_tx against a
// frame-level line model; honours PC2MCU_UART_PARITY_EN for 8E1 frames.
`timescale 1ns/1ps
module tb_pc2mcu_uart_tx;

   localparam int CLK_HZ = 1_152_000;
   localparam int DEPTH  = 16;
`ifdef PC2MCU_UART_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [2:0] tx_baud = 3'd0;
   logic [7:0] wr_dat = 8'h00;
   logic       wr_en = 1'b0;
   logic       full, empty, ovf, tx, tx_ing, tx_ok;
   logic [4:0] level;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   // Expected frames as div*256+byte, and the cycle each observed frame began.
   int expQ[$];
   int starts[$];

   bit          monActive = 1'b0;
   bit          pendingOk = 1'b0;
   bit          bitOk = 1'b1;
   int          monIdx = 0;
   int          monDiv = 1;
   logic [10:0] monBits = '1;

   pc2mcu_uart_tx #(.CLK_HZ(CLK_HZ), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rstn(rstn), .tx_baud(tx_baud), .wr_dat(wr_dat), .wr_en(wr_en),
      .full(full), .empty(empty), .level(level), .ovf(ovf),
      .tx(tx), .tx_ing(tx_ing), .tx_ok(tx_ok)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int divOf(input logic [2:0] b);
      int rate;
      case (b)
         3'd1:    rate = 57600;
         3'd2:    rate = 38400;
         3'd3:    rate = 19200;
         3'd4:    rate = 9600;
         default: rate = 115200;
      endcase
      return CLK_HZ / rate;
   endfunction

   function automatic logic [10:0] frameBits(input logic [7:0] d);
      logic [10:0] f;
      f = {2'b11, d, 1'b0};
`ifdef PC2MCU_UART_PARITY_EN
      f[9] = ^d;
`endif
      return f;
   endfunction

   // One-clock write; accepted bytes are queued for the line model.
   task automatic applyStimulus(input logic [7:0] d, input bit accept, input int div);
      wr_en  = 1'b1;
      wr_dat = d;
      if (accept) expQ.push_back(div * 256 + int'(d));
      tick();
      wr_en = 1'b0;
   endtask

   task automatic waitIdle(input int maxCyc);
      int n;
      n = 0;
      while ((expQ.size() != 0 || monActive || pendingOk) && n < maxCyc) begin
         tick();
         n++;
      end
      checkOutput("drain_timeout", 32'(expQ.size() != 0 || monActive || pendingOk), 0);
   endtask

   // Line monitor: every frame must match the next expected byte, bit by bit,
   // with each bit held exactly div cycles and tx_ok right after the stop bit.
   always @(negedge clk) begin
      int ent;
      if (!rstn) begin
         monActive = 1'b0;
         pendingOk = 1'b0;
      end else begin
         if (pendingOk) begin
            checkOutput("tx_ok_pulse", 32'(tx_ok), 1);
            checkOutput("tx_ing_end", 32'(tx_ing), 0);
            pendingOk = 1'b0;
         end else if (!monActive) begin
            if (tx === 1'b0) begin
               checkOutput("frame_expected", 32'(expQ.size() > 0), 1);
               if (expQ.size() > 0) begin
                  ent       = expQ.pop_front();
                  monDiv    = ent / 256;
                  monBits   = frameBits(8'(ent % 256));
                  monIdx    = 0;
                  bitOk     = 1'b1;
                  monActive = 1'b1;
                  starts.push_back(cyc);
               end
            end else begin
               checkOutput("idle_quiet", {29'd0, tx_ok, tx_ing, tx}, 32'h1);
            end
         end
         if (monActive) begin
            bitOk &= (tx === monBits[4'(monIdx / monDiv)]) && (tx_ing === 1'b1) && (tx_ok === 1'b0);
            if (monIdx % monDiv == monDiv - 1) begin
               checkOutput($sformatf("frame_bit%0d", monIdx / monDiv), 32'(bitOk), 1);
               bitOk = 1'b1;
            end
            monIdx++;
            if (monIdx == NBITS * monDiv) begin
               monActive = 1'b0;
               pendingOk = 1'b1;
            end
         end
      end
   end

   initial begin
      logic [2:0] b;
      logic [7:0] d;
      int fillerStart, baseIdx, nStarts;

      // Reset state.
      tick();
      tick();
      checkOutput("rst_tx", 32'(tx), 1);
      checkOutput("rst_tx_ing", 32'(tx_ing), 0);
      checkOutput("rst_tx_ok", 32'(tx_ok), 0);
      checkOutput("rst_ovf", 32'(ovf), 0);
      checkOutput("rst_empty", 32'(empty), 1);
      checkOutput("rst_full", 32'(full), 0);
      checkOutput("rst_level", 32'(level), 0);
      rstn = 1'b1;
      tick();

      // Single 0xA5 at baud 0 and its two-cycle start latency.
      tx_baud = 3'd0;
      applyStimulus(8'hA5, 1'b1, divOf(3'd0));
      checkOutput("lat_empty", 32'(empty), 0);
      checkOutput("lat_level", 32'(level), 1);
      tick();
      checkOutput("lat_tx_n1", 32'(tx), 1);
      checkOutput("lat_ing_n1", 32'(tx_ing), 0);
      tick();
      checkOutput("lat_tx_n2", 32'(tx), 0);
      checkOutput("lat_ing_n2", 32'(tx_ing), 1);
      waitIdle(400);

      // Random bytes at random baud selections.
      for (int i = 0; i < 5; i++) begin
         b = 3'($urandom_range(0, 7));
         d = 8'($urandom);
         tx_baud = b;
         applyStimulus(d, 1'b1, divOf(b));
         waitIdle(2000);
      end

      // Burst of 16 behind a filler frame, overflow, then write-with-pop.
      tx_baud = 3'd0;
      applyStimulus(8'($urandom), 1'b1, 10);
      tick();
      for (int i = 0; i < DEPTH; i++) applyStimulus(8'(i), 1'b1, 10);
      checkOutput("burst_full", 32'(full), 1);
      checkOutput("burst_level", 32'(level), 16);
      applyStimulus(8'hFF, 1'b0, 10);
      checkOutput("ovf_pulse", 32'(ovf), 1);
      checkOutput("ovf_level", 32'(level), 16);
      tick();
      checkOutput("ovf_clear", 32'(ovf), 0);
      fillerStart = starts[starts.size() - 1];
      baseIdx = starts.size() - 1;
      while (cyc < fillerStart + NBITS * 10 - 1) tick();
      applyStimulus(8'hEE, 1'b0, 10);
      checkOutput("popwr_ovf", 32'(ovf), 1);
      checkOutput("popwr_level", 32'(level), 15);
      checkOutput("popwr_full", 32'(full), 0);
      waitIdle(4000);
      checkOutput("burst_count", 32'(starts.size()), 32'(baseIdx + DEPTH + 1));
      for (int k = 1; k <= DEPTH; k++) begin
         if (baseIdx + k < starts.size())
            checkOutput($sformatf("burst_gap%0d", k), 32'(starts[baseIdx + k] - starts[baseIdx + k - 1]), 32'(NBITS * 10 + 1));
      end
      checkOutput("burst_empty", 32'(empty), 1);
      checkOutput("burst_level0", 32'(level), 0);

      // Baud change mid-frame only affects the following frame.
      tx_baud = 3'd4;
      applyStimulus(8'h55, 1'b1, 120);
      repeat (300) tick();
      tx_baud = 3'd0;
      applyStimulus(8'($urandom), 1'b1, 10);
      waitIdle(3000);

      // Asynchronous reset during DATA of a three-byte queue.
      applyStimulus(8'h00, 1'b1, 10);
      applyStimulus(8'($urandom), 1'b1, 10);
      applyStimulus(8'($urandom), 1'b1, 10);
      repeat (30) tick();
      nStarts = starts.size();
      rstn = 1'b0;
      #1;
      checkOutput("arst_tx", 32'(tx), 1);
      checkOutput("arst_ing", 32'(tx_ing), 0);
      expQ.delete();
      tick();
      rstn = 1'b1;
      tick();
      checkOutput("arst_empty", 32'(empty), 1);
      checkOutput("arst_level", 32'(level), 0);
      repeat (300) tick();
      checkOutput("arst_no_frames", 32'(starts.size()), 32'(nStarts));

`ifdef PC2MCU_UART_PARITY_EN
      // Even parity bit: 0x07 gives 1, 0x03 gives 0.
      tx_baud = 3'd0;
      applyStimulus(8'h07, 1'b1, 10);
      waitIdle(400);
      applyStimulus(8'h03, 1'b1, 10);
      waitIdle(400);
`endif

      checkOutput("queue_drained", 32'(expQ.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc2mcu_uart_tx.md
# pc2mcu_uart_tx

Buffered UART transmitter for the PC-to-MCU direction of the debug bridge. Upstream logic pushes bytes into an internal FIFO; the block drains it and serializes each byte as an 8N1 frame, or 8E1 with the parity option, on `tx` at a run-time selectable baud rate. It pairs with the existing MCU-to-PC receive path and presents the same 3-bit baud encoding and `tx_ing`/`tx_ok` status semantics.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency. Bit divisor `DIV = CLK_HZ / baud`, integer-truncated at elaboration.
- `FIFO_DEPTH`, 16: FIFO entries; must be a power of 2, ≥ 2.
- `clk`  in  1  system clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `tx_baud`  in  3  0=115200, 1=57600, 2=38400, 3=19200, 4=9600, 5–7=115200. Sampled only at frame start.
- `wr_dat`  in  8  byte to transmit.
- `wr_en`  in  1  push `wr_dat` when high for one clock.
- `full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `empty`  out  1  FIFO holds 0 entries.
- `level`  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- `ovf`  out  1  one-cycle pulse when a write is dropped.
- `tx`  out  1  serial output; idle high.
- `tx_ing`  out  1  high from the start-bit cycle through the last stop-bit cycle.
- `tx_ok`  out  1  one-cycle pulse in the cycle after a stop bit completes.

## Operation
- FIFO: registered write and read pointers, each 1 bit wider than the address for full/empty detection. No write-to-read bypass.
- Write handling: a write is accepted when `wr_en` is high and `full` is low.
  - `full` is evaluated before the same cycle's read.
  - A write while full is dropped and pulses `ovf`, even if a pop happens in that cycle.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE: if `!empty`, pop the head into a shift register, latch the divisor for `tx_baud`, then go to START.
  - START: `tx`=0 for DIV cycles.
  - DATA: 8 bits, LSB first, DIV cycles each. A 3-bit counter counts bits.
  - PARITY (only with the macro): even parity of the byte, DIV cycles.
  - STOP: `tx`=1 for DIV cycles. Then `tx_ok` pulses and the FSM returns to IDLE.
- Back-to-back frames: if the FIFO is non-empty at the IDLE cycle, the next start bit follows immediately. The inter-frame gap is 1 clock of idle-high.
- Baud counter: counts DIV-1 down to 0. It reloads at each bit boundary and uses ceil(log2(CLK_HZ/9600)) bits.
- A `tx_baud` change mid-frame has no effect until the next frame.

## Timing
- Reset values:
  - `tx`=1, `tx_ing`=0, `tx_ok`=0, `ovf`=0.
  - `empty`=1, `full`=0, `level`=0.
  - FSM in IDLE; pointers cleared.
- Reset asserted mid-frame: `tx` goes to 1 asynchronously, and FIFO contents are discarded.
- Latency from an empty, idle start:
  - `wr_en` at edge N.
  - `empty` falls after edge N.
  - Pop occurs at edge N+1.
  - `tx`=0 and `tx_ing`=1 after edge N+2.
- Frame length: 10×DIV cycles, or 11×DIV with parity. `tx_ing` is high for exactly that many cycles.
- `level` and `full` update the cycle after a push. On a simultaneous push and pop, `level` is unchanged.
- All outputs are registered.

## Configuration
- `PC2MCU_UART_PARITY_EN` defined:
  - PARITY state is compiled in.
  - Frame is 8E1, 11 bits.
- Undefined:
  - State and parity logic are absent.
  - Frame is 8N1, 10 bits.
  - `tx_ok` occurs 10×DIV+1 cycles after the frame starts.

## Test plan
Use `CLK_HZ`=1_152_000 so that DIV is 10 at 115200 (baud 0) and DIV is 120 at 9600 (baud 4).
- Reset then single write 0xA5 at baud 0: `tx` low 2 cycles after `wr_en`.
  - Bit sequence 0,1,0,1,0,0,1,0,1,1, each held 10 cycles.
  - `tx_ok` pulses once; `tx_ing` is high for 100 cycles.
- Burst of 16 writes (0x00..0x0F): `full`=1 and `level`=16 one cycle after the 16th write.
  - A 17th write of 0xFF pulses `ovf` and is never transmitted.
  - 16 frames are sent back-to-back, each separated by 1 idle cycle.
- `tx_baud`=4, write 0x55, and switch `tx_baud` to 0 mid-frame: the entire frame uses 120-cycle bits. The next frame uses 10-cycle bits.
- `rstn` pulsed low during DATA of a 3-byte queue:
  - `tx`=1 immediately.
  - After release, `empty`=1 and no further frames are sent.
- Write while full with a simultaneous pop: the write is dropped, `ovf`=1, and `level` goes from 16 to 15.
- With `PC2MCU_UART_PARITY_EN`, write 0x07: the parity bit is 1 and the frame lasts 110 cycles.
  - Write 0x03: the parity bit is 0.
